fifo_write_arbiter: RTL and testbench

Round-robin arbiter that shares the single write port of a FIFO among NUM_REQ requesters.
- Each grant is a burst of up to MAX_BURST words.
- The FIFO's full flag back-pressures the granted requester.
- Sits in the write clock domain in front of the FIFO; its fifo_* outputs drive the FIFO's wr_en/data_in directly.

---
 rtl/fifo_write_arbiter_pkg.sv | 14 +
 rtl/fifo_write_arbiter_rr_pick.sv | 35 +++
 rtl/fifo_write_arbiter.sv | 113 +++++++++++
 tb/tb_fifo_write_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_write_arbiter_pkg.sv
// Shared constants and FSM encoding for the FIFO write-port arbiter.
// Purely declarative: no latency and no flow control of its own.
package fifo_write_arbiter_pkg;

    localparam int FIFO_DATA_WIDTH = 8;
    localparam int ARB_NUM_REQ     = 4;
    localparam int ARB_MAX_BURST   = 4;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

endpackage

// File: rtl/fifo_write_arbiter_rr_pick.sv
// Rotating-priority encoder: first set request after last_owner, wrapping; 0-cycle latency.
// No backpressure; found_o=0 when no request is pending.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDXW    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDXW-1:0]    last_owner_i,
    output logic               found_o,
    output logic [IDXW-1:0]    index_o
);

    int              cand;
    logic [IDXW-1:0] cand_idx;

    // Offsets 1..NUM_REQ put last_owner itself at the very end of the scan.
    always_comb begin
        found_o  = 1'b0;
        index_o  = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = int'(last_owner_i) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IDXW'(cand);
            if (!found_o && req_i[cand_idx]) begin
                found_o = 1'b1;
                index_o = cand_idx;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter for one FIFO write port; one-cycle bubble from idle, 0-cycle write path.
// fifo_full drops gnt and freezes the burst; owner withdrawal or MAX_BURST beats ends it.
module fifo_write_arbiter
    import fifo_write_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int NUM_REQ    = ARB_NUM_REQ,
    parameter int MAX_BURST  = ARB_MAX_BURST
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data_in,
    output logic [$clog2(NUM_REQ)-1:0]    owner,
    output logic                          busy
);

    localparam int IDXW = $clog2(NUM_REQ);
    localparam int CNTW = $clog2(MAX_BURST + 1);

    arb_state_e      state_q, state_d;
    logic [IDXW-1:0] owner_q, owner_d;
    logic [IDXW-1:0] last_owner_q, last_owner_d;
    logic [CNTW-1:0] beat_cnt_q, beat_cnt_d;

    logic [DATA_WIDTH-1:0] words [NUM_REQ];
    logic [IDXW-1:0]       pick_base;
    logic                  pick_found;
    logic [IDXW-1:0]       pick_idx;
    logic                  accept;
    logic                  burst_end;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign words[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // In BURST the pick is only consumed at burst end, where the current owner
    // becomes the new lowest-priority slot; that lets one encoder serve both paths.
    assign pick_base = (state_q == ARB_BURST) ? owner_q : last_owner_q;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDXW    (IDXW)
    ) u_pick (
        .req_i        (req),
        .last_owner_i (pick_base),
        .found_o      (pick_found),
        .index_o      (pick_idx)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        beat_cnt_d   = beat_cnt_q;
        gnt          = '0;
        accept       = 1'b0;
        burst_end    = 1'b0;
        fifo_data_in = '0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    owner_d    = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = ARB_BURST;
                end
            end
            ARB_BURST: begin
                gnt[owner_q] = ~fifo_full;
                accept       = req[owner_q] & ~fifo_full;
                if (accept) begin
                    fifo_data_in = words[owner_q];
                    beat_cnt_d   = beat_cnt_q + 1'b1;
                end
                burst_end = (accept && (beat_cnt_q == CNTW'(MAX_BURST - 1))) ||
                            (!req[owner_q] && !accept);
                if (burst_end) begin
                    last_owner_d = owner_q;
                    beat_cnt_d   = '0;
                    if (pick_found) begin
                        owner_d = pick_idx;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign fifo_wr_en = accept;
    assign owner      = owner_q;
    assign busy       = (state_q == ARB_BURST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            owner_q      <= '0;
            last_owner_q <= IDXW'(NUM_REQ - 1);
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: directed bursts, stall, withdrawal, reset and a random phase.
module tb_fifo_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [7:0]  fifo_data_in;
    logic [1:0]  owner;
    logic        busy;

    always #5 clk = ~clk;

    fifo_write_arbiter #(
        .DATA_WIDTH (8),
        .NUM_REQ    (4),
        .MAX_BURST  (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_data     (req_data),
        .gnt          (gnt),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_data_in (fifo_data_in),
        .owner        (owner),
        .busy         (busy)
    );

    logic [7:0] src   [4][$];
    logic [7:0] exp_r [4][$];
    logic [7:0] exp_q [$];
    int         pass_cnt  = 0;
    int         total_cnt = 0;
    bit         chk_en    = 1'b0;
    bit         rand_mode = 1'b0;
    logic       rst_sched;
    logic       full_sched;
    logic [3:0] acc;
    int         wait_cnt [4];
    int         max_wait = 0;
    int         seq      [4];

    function automatic logic [7:0] mkw(int i, int k);
        return 8'((i << 6) | (k & 63));
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] expv);
        total_cnt++;
        if (act === expv) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            req[i] = (src[i].size() > 0);
            req_data[i*8 +: 8] = (src[i].size() > 0) ? src[i][0] : 8'h00;
        end
    endtask

    // One clock: apply inputs just after posedge, settle, sample at negedge.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) if (acc[i] === 1'b1) void'(src[i].pop_front());
        rst       = rst_sched;
        fifo_full = full_sched;
        drive();
        @(negedge clk);
        acc = req & gnt;
        if (chk_en) begin
            for (int i = 0; i < 4; i++) begin
                if (req[i] && !acc[i]) wait_cnt[i] += $countones(acc);
                else wait_cnt[i] = 0;
                if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
            end
        end
    endtask

    task automatic do_reset();
        rst_sched = 1'b1;
        step();
        rst_sched = 1'b0;
        step();
        for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
    endtask

    task automatic load(int i, int n);
        for (int k = 0; k < n; k++) src[i].push_back(mkw(i, k));
    endtask

    task automatic expect_w(int i, int k0, int n);
        for (int k = k0; k < k0 + n; k++) exp_q.push_back(mkw(i, k));
    endtask

    task automatic drain(string name);
        int n = 0;
        while ((src[0].size() + src[1].size() + src[2].size() + src[3].size() +
                exp_q.size()) > 0 && n < 300) begin
            step();
            n++;
        end
        repeat (3) step();
        check({name, "_drain_timeout"}, (n < 300), 1);
        check({name, "_idle_after"}, busy, 0);
    endtask

    // Monitor: pops the scoreboard on every FIFO write and checks invariants.
    always @(negedge clk) begin
        if (chk_en) begin
            check("gnt_onehot0", $onehot0(gnt), 1);
            check("no_write_when_full", (fifo_wr_en && fifo_full), 0);
            if (fifo_wr_en) begin
                if (rand_mode) begin
                    if (exp_r[owner].size() == 0) check("rand_underflow", 1, 0);
                    else check("rand_data", fifo_data_in, exp_r[owner].pop_front());
                end else begin
                    if (exp_q.size() == 0) check("dir_underflow", 1, 0);
                    else check("dir_data", fifo_data_in, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; fifo_full = 1'b0; req = '0; req_data = '0;
        rst_sched = 1'b1; full_sched = 1'b0; acc = '0;
        do_reset();
        chk_en = 1'b1;

        // Fairness round: all four requesters held across reset release.
        for (int i = 0; i < 4; i++) begin load(i, 4); expect_w(i, 0, 4); end
        do_reset();
        check("t1_rst_busy", busy, 0);
        check("t1_rst_gnt", gnt, 0);
        check("t1_rst_wr", fifo_wr_en, 0);
        check("t1_rst_owner", owner, 0);
        for (int k = 0; k < 16; k++) begin
            step();
            check("t1_gnt", gnt, 32'(1 << (k / 4)));
            check("t1_wr", fifo_wr_en, 1);
        end
        drain("t1");

        // Single requester, 10 words: bursts 4,4,2 back to back.
        load(2, 10); expect_w(2, 0, 10);
        do_reset();
        check("t2_idle_bubble", busy, 0);
        for (int k = 0; k < 10; k++) begin
            step();
            check("t2_gnt", gnt, 4);
            check("t2_wr", fifo_wr_en, 1);
            check("t2_owner", owner, 2);
        end
        step();
        check("t2_withdraw_busy", busy, 1);
        check("t2_withdraw_wr", fifo_wr_en, 0);
        step();
        check("t2_idle", busy, 0);
        drain("t2");

        // fifo_full stall after two beats of requester 0.
        load(0, 4); load(1, 2); expect_w(0, 0, 4); expect_w(1, 0, 2);
        do_reset();
        step(); step();
        full_sched = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("t3_stall_gnt", gnt, 0);
            check("t3_stall_wr", fifo_wr_en, 0);
            check("t3_stall_owner", owner, 0);
            check("t3_stall_cnt", dut.beat_cnt_q, 2);
        end
        full_sched = 1'b0;
        step();
        check("t3_resume_gnt", gnt, 1);
        check("t3_resume_wr", fifo_wr_en, 1);
        drain("t3");

        // Owner withdrawal hands over to requester 3.
        load(1, 1); load(3, 3); expect_w(1, 0, 1); expect_w(3, 0, 3);
        do_reset();
        step();
        check("t4_gnt1", gnt, 2);
        check("t4_wr1", fifo_wr_en, 1);
        step();
        check("t4_drop_wr", fifo_wr_en, 0);
        check("t4_drop_busy", busy, 1);
        step();
        check("t4_owner3", owner, 3);
        check("t4_gnt3", gnt, 8);
        check("t4_last_owner", dut.last_owner_q, 1);
        drain("t4");

        // Reset pulse mid-burst of requester 2; requester 0 wins afterwards.
        load(2, 4);
        expect_w(2, 0, 3); expect_w(0, 0, 2); expect_w(2, 3, 1);
        do_reset();
        step(); step();
        load(0, 2);
        rst_sched = 1'b1;
        step();
        check("t5_pre_rst_wr", fifo_wr_en, 1);
        rst_sched = 1'b0;
        step();
        check("t5_rst_busy", busy, 0);
        check("t5_rst_gnt", gnt, 0);
        check("t5_rst_wr", fifo_wr_en, 0);
        step();
        check("t5_owner0", owner, 0);
        check("t5_gnt0", gnt, 1);
        drain("t5");

        // Random requests and stalls: per-requester order and starvation bound.
        rand_mode = 1'b1;
        max_wait  = 0;
        for (int i = 0; i < 4; i++) seq[i] = 0;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (src[i].size() == 0 && $urandom_range(0, 3) == 0) begin
                    int n = int'($urandom_range(1, 6));
                    for (int k = 0; k < n; k++) begin
                        src[i].push_back(mkw(i, seq[i]));
                        exp_r[i].push_back(mkw(i, seq[i]));
                        seq[i]++;
                    end
                end
            end
            full_sched = ($urandom_range(0, 4) == 0);
            step();
        end
        full_sched = 1'b0;
        drain("rand");
        check("rand_leftover",
              32'(exp_r[0].size() + exp_r[1].size() + exp_r[2].size() + exp_r[3].size()), 0);
        total_cnt++;
        if (max_wait <= 12) pass_cnt++;
        else $display("FAIL starvation: max wait %0d words, bound 12", max_wait);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
